dccm_port_arbiter: RTL and testbench

- Shares the single DCCM port of the ccm between two requesters: the rv32i_x core load/store path and a DMA/loader master.
- The core normally has priority and is stalled only when the DMA wins a cycle.
- Starvation control guarantees DMA forward progress.
- Read-return tagging routes dccm_rd_data back to the requester that issued the read.
- Sits between rv32i_x and ccm in the top wrapper. Byte addresses pass through; the wrapper still does the word shift.

---
 rtl/dccm_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dccm_port_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_port_arbiter.sv
// ---------------------------------------------------------------------------
// dccm_port_arbiter
//
// Shares the single DCCM port between the rv32i_x load/store path and a
// DMA/loader master. The core has priority; a DMA request that keeps losing
// is forced through after STARVE_LIMIT consecutive losses. Read data coming
// back from the DCCM is steered to whichever requester issued the read,
// using a small tag pipeline that mirrors the memory read latency.
//
// Byte addresses pass straight through; the surrounding wrapper performs the
// word shift toward the memory macro.
//
// Handshake summary (single source of truth for both requesters):
//   core : a request is core_rd_en | core_wr_en. If core_stall is high in a
//          cycle the access was not taken and the core must hold the same
//          request into the next cycle. A request with core_stall low is
//          taken in that cycle.
//   dma  : dma_req with dma_we/dma_addr/dma_wdata is held stable until a
//          cycle in which dma_gnt is high; that cycle is the transfer.
//   read return : exactly RD_LATENCY cycles after a taken read, the owner's
//          *_rd_valid/dma_rvalid pulses for one cycle alongside the data.
//
// Parameters:
//   STARVE_LIMIT  consecutive losses a pending DMA request may suffer
//   RD_LATENCY    dccm_rd_en to dccm_rd_data latency, legal range 1..4
//   AW            address width
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   core_rd_en / core_wr_en       core load / store request
//   core_addr, core_wr_data       core byte address and store data
//   core_store_type/offset        store width (00 b, 01 h, 10 w) and lane
//   core_stall                    core request not taken this cycle
//   core_rd_data/core_rd_valid    load return
//   dma_req/dma_we/dma_addr       DMA request, direction, byte address
//   dma_wdata                     DMA store data (always a full word)
//   dma_gnt                       DMA request accepted this cycle
//   dma_rdata/dma_rvalid          DMA read return
//   dccm_rd_en/dccm_wr_en         memory strobes
//   dccm_rd_addr/dccm_wr_addr     memory byte addresses (winner's address)
//   dccm_wr_data                  memory write data
//   store_type/store_offset       memory write qualifiers
//   dccm_rd_data                  memory read data
//   fsm_state                     arbiter state (0 CORE_PRI, 1 DMA_FORCE)
//   starve_count                  current DMA starvation counter
// ---------------------------------------------------------------------------
module dccm_port_arbiter #(
   parameter int  STARVE_LIMIT = 4,
   parameter int  RD_LATENCY   = 1,
   parameter int  AW           = 32,
   localparam int CW           = $clog2(STARVE_LIMIT + 1)
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          core_rd_en,
   input  logic          core_wr_en,
   input  logic [AW-1:0] core_addr,
   input  logic [31:0]   core_wr_data,
   input  logic [1:0]    core_store_type,
   input  logic [1:0]    core_store_offset,
   output logic          core_stall,
   output logic [31:0]   core_rd_data,
   output logic          core_rd_valid,

   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [31:0]   dma_wdata,
   output logic          dma_gnt,
   output logic [31:0]   dma_rdata,
   output logic          dma_rvalid,

   output logic          dccm_rd_en,
   output logic          dccm_wr_en,
   output logic [AW-1:0] dccm_rd_addr,
   output logic [AW-1:0] dccm_wr_addr,
   output logic [31:0]   dccm_wr_data,
   output logic [1:0]    store_type,
   output logic [1:0]    store_offset,
   input  logic [31:0]   dccm_rd_data,

   output logic          fsm_state,
   output logic [CW-1:0] starve_count
);

   typedef enum logic {
      CORE_PRI  = 1'b0,
      DMA_FORCE = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   logic            core_req;
   logic            core_win;
   logic            dma_win;
   logic            any_win;
   logic [AW-1:0]   dma_word_addr;
   logic [AW-1:0]   win_addr;

   // Last driven address / write payload, presented while nobody is granted.
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic [1:0]      stype_q;
   logic [1:0]      soff_q;

   // Read-return tag pipeline: one {valid, owner} slot per cycle of latency.
   // owner = 1 marks a DMA read, 0 a core read.
   logic [RD_LATENCY-1:0] tag_valid;
   logic [RD_LATENCY-1:0] tag_owner;
   logic                  tail_valid;
   logic                  tail_owner;

   assign core_req      = core_rd_en | core_wr_en;
   // Masking rather than slicing keeps every address bit in use.
   assign dma_word_addr = dma_addr & ~AW'(3);

   // ------------------------------------------------------------------
   // Arbitration FSM: next state, counter and grants
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      core_win = 1'b0;
      dma_win  = 1'b0;

      unique case (state_q)
         CORE_PRI: begin
            if (core_req) begin
               core_win = 1'b1;
            end else if (dma_req) begin
               dma_win = 1'b1;
            end

            if (dma_req && !dma_win) begin
               // Losing with the counter already at LIMIT-1 means this
               // was the last loss the DMA is allowed.
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(STARVE_LIMIT - 1)) begin
                  state_d = DMA_FORCE;
               end
            end else begin
               cnt_d = '0;
            end
         end

         DMA_FORCE: begin
            // The core never wins here; if the DMA withdrew its request
            // the cycle simply goes unused.
            dma_win = dma_req;
            state_d = CORE_PRI;
            cnt_d   = '0;
         end

         default: begin
            state_d = CORE_PRI;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CORE_PRI;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fsm_state    = state_q;
   assign starve_count = cnt_q;

   // ------------------------------------------------------------------
   // Request-path muxing toward the DCCM (same cycle as the grant)
   // ------------------------------------------------------------------
   assign any_win  = core_win | dma_win;
   assign win_addr = core_win ? core_addr : dma_word_addr;

   always_comb begin
      core_stall   = core_req & ~core_win;
      dma_gnt      = dma_win;
      dccm_rd_en   = 1'b0;
      dccm_wr_en   = 1'b0;
      dccm_rd_addr = addr_q;
      dccm_wr_addr = addr_q;
      dccm_wr_data = wdata_q;
      store_type   = stype_q;
      store_offset = soff_q;

      if (core_win) begin
         // A simultaneous read and write from the core keeps only the write.
         dccm_wr_en = core_wr_en;
         dccm_rd_en = core_rd_en & ~core_wr_en;
      end else if (dma_win) begin
         dccm_wr_en = dma_we;
         dccm_rd_en = ~dma_we;
      end

      if (any_win) begin
         dccm_rd_addr = win_addr;
         dccm_wr_addr = win_addr;
      end

      if (dccm_wr_en) begin
         if (core_win) begin
            dccm_wr_data = core_wr_data;
            store_type   = core_store_type;
            store_offset = core_store_offset;
         end else begin
            dccm_wr_data = dma_wdata;
            store_type   = 2'b10;
            store_offset = 2'b00;
         end
      end
   end

   // Hold registers: address follows every grant, write payload follows
   // only granted writes so a later read leaves it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         stype_q <= '0;
         soff_q  <= '0;
      end else begin
         if (any_win) begin
            addr_q <= win_addr;
         end
         if (dccm_wr_en) begin
            wdata_q <= dccm_wr_data;
            stype_q <= store_type;
            soff_q  <= store_offset;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read-return tagging
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid <= '0;
         tag_owner <= '0;
      end else begin
         tag_valid[0] <= dccm_rd_en;
         tag_owner[0] <= dma_win;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_owner[i] <= tag_owner[i-1];
         end
      end
   end

   assign tail_valid = tag_valid[RD_LATENCY-1];
   assign tail_owner = tag_owner[RD_LATENCY-1];

   assign core_rd_valid = tail_valid & ~tail_owner;
   assign dma_rvalid    = tail_valid & tail_owner;

   // Both requesters see the returning word; the data buses read as zero
   // whenever no return is in progress, which also keeps them quiet in reset.
   assign core_rd_data = tail_valid ? dccm_rd_data : 32'h0;
   assign dma_rdata    = tail_valid ? dccm_rd_data : 32'h0;

`ifndef SYNTHESIS
   // A core read and write in the same cycle is a protocol error.
   core_rd_wr_exclusive : assert property (
      @(posedge clk) disable iff (rst) !(core_rd_en && core_wr_en)
   );
`endif

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dccm_port_arbiter
//
// Table of single-cycle vectors, directed multi-cycle sequences (core load,
// starvation, interleaved returns, request withdrawn in the forced cycle,
// reset during an outstanding read) and a randomized run. Every cycle is
// also checked against a reference model that tracks the DMA losing streak
// as a plain integer and the expected read returns as a queue.
// ---------------------------------------------------------------------------
module tb_dccm_port_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int RD_LATENCY   = 2;
   localparam int AW           = 32;
   localparam int CW           = $clog2(STARVE_LIMIT + 1);
   localparam int EW           = 65;   // {due cycle[31:0], owner, data[31:0]}

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT signals ----------------
   logic          c_rd, c_wr;
   logic [AW-1:0] c_addr;
   logic [31:0]   c_wdata;
   logic [1:0]    c_type, c_off;
   logic          d_req, d_we;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;

   logic          core_stall, core_rd_valid, dma_gnt, dma_rvalid;
   logic [31:0]   core_rd_data, dma_rdata;
   logic          dccm_rd_en, dccm_wr_en;
   logic [AW-1:0] dccm_rd_addr, dccm_wr_addr;
   logic [31:0]   dccm_wr_data, dccm_rd_data;
   logic [1:0]    store_type, store_offset;
   logic          fsm_state;
   logic [CW-1:0] starve_count;

   dccm_port_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .RD_LATENCY  (RD_LATENCY),
      .AW          (AW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .core_rd_en       (c_rd),
      .core_wr_en       (c_wr),
      .core_addr        (c_addr),
      .core_wr_data     (c_wdata),
      .core_store_type  (c_type),
      .core_store_offset(c_off),
      .core_stall       (core_stall),
      .core_rd_data     (core_rd_data),
      .core_rd_valid    (core_rd_valid),
      .dma_req          (d_req),
      .dma_we           (d_we),
      .dma_addr         (d_addr),
      .dma_wdata        (d_wdata),
      .dma_gnt          (dma_gnt),
      .dma_rdata        (dma_rdata),
      .dma_rvalid       (dma_rvalid),
      .dccm_rd_en       (dccm_rd_en),
      .dccm_wr_en       (dccm_wr_en),
      .dccm_rd_addr     (dccm_rd_addr),
      .dccm_wr_addr     (dccm_wr_addr),
      .dccm_wr_data     (dccm_wr_data),
      .store_type       (store_type),
      .store_offset     (store_offset),
      .dccm_rd_data     (dccm_rd_data),
      .fsm_state        (fsm_state),
      .starve_count     (starve_count)
   );

   // ---------------- memory model ----------------
   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_pipe [RD_LATENCY];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   always @(posedge clk) begin
      rd_pipe[0] <= dccm_rd_en ? mem_read(dccm_rd_addr) : 32'hBAD0_BAD0;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign dccm_rd_data = rd_pipe[RD_LATENCY-1];

   // ---------------- scoreboard / model state ----------------
   int               checks;
   int               errors;
   int               cycle;
   int               streak;
   logic [AW-1:0]    m_addr;
   logic [31:0]      m_wdata;
   logic [1:0]       m_type, m_off;
   logic             last_dgnt;
   logic [EW-1:0]    exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      streak    = 0;
      m_addr    = '0;
      m_wdata   = '0;
      m_type    = '0;
      m_off     = '0;
      last_dgnt = 1'b0;
   endtask

   task automatic set_idle();
      c_rd  = 1'b0;
      c_wr  = 1'b0;
      d_req = 1'b0;
   endtask

   // Settle to mid-cycle, compare every output with the model, advance model.
   task automatic eval_cycle();
      logic          creq, cwin, dwin, e_rd, e_wr, e_cv, e_dv;
      logic [31:0]   e_data;
      logic [EW-1:0] ent;
      int            nstreak;
      #4;
      creq = c_rd | c_wr;
      if (streak == STARVE_LIMIT) begin
         cwin    = 1'b0;
         dwin    = d_req;
         nstreak = 0;
      end else begin
         cwin    = creq;
         dwin    = !creq && d_req;
         nstreak = (d_req && !dwin) ? streak + 1 : 0;
      end
      e_rd = cwin ? (c_rd && !c_wr) : (dwin && !d_we);
      e_wr = cwin ? c_wr : (dwin && d_we);
      if (cwin || dwin) m_addr = cwin ? c_addr : (d_addr & ~32'h3);
      if (e_wr) begin
         m_wdata = cwin ? c_wdata : d_wdata;
         m_type  = cwin ? c_type  : 2'b10;
         m_off   = cwin ? c_off   : 2'b00;
      end

      chk("core_stall",   64'(core_stall),   64'(creq && !cwin));
      chk("dma_gnt",      64'(dma_gnt),      64'(dwin));
      chk("dccm_rd_en",   64'(dccm_rd_en),   64'(e_rd));
      chk("dccm_wr_en",   64'(dccm_wr_en),   64'(e_wr));
      chk("dccm_rd_addr", 64'(dccm_rd_addr), 64'(m_addr));
      chk("dccm_wr_addr", 64'(dccm_wr_addr), 64'(m_addr));
      chk("dccm_wr_data", 64'(dccm_wr_data), 64'(m_wdata));
      chk("store_type",   64'(store_type),   64'(m_type));
      chk("store_offset", 64'(store_offset), 64'(m_off));
      chk("fsm_state",    64'(fsm_state),    64'(streak == STARVE_LIMIT));
      if (streak < STARVE_LIMIT) chk("starve_count", 64'(starve_count), 64'(streak));

      e_cv   = 1'b0;
      e_dv   = 1'b0;
      e_data = '0;
      if (exp_q.size() > 0 && exp_q[0][64:33] == 32'(cycle)) begin
         ent    = exp_q.pop_front();
         e_cv   = !ent[32];
         e_dv   = ent[32];
         e_data = ent[31:0];
      end
      chk("core_rd_valid", 64'(core_rd_valid), 64'(e_cv));
      chk("dma_rvalid",    64'(dma_rvalid),    64'(e_dv));
      if (e_cv) chk("core_rd_data", 64'(core_rd_data), 64'(e_data));
      if (e_dv) chk("dma_rdata",    64'(dma_rdata),    64'(e_data));

      if (e_rd) exp_q.push_back({32'(cycle + RD_LATENCY), dwin, mem_read(m_addr)});
      streak    = nstreak;
      last_dgnt = dwin;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      for (int i = 0; i < n; i++) begin
         eval_cycle();
         next_cycle();
      end
   endtask

   // Assert reset with requests dropped; all outputs must read zero at once.
   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      #1;
      chk("rst_core_stall",   64'(core_stall),    64'(0));
      chk("rst_core_rd_valid",64'(core_rd_valid), 64'(0));
      chk("rst_core_rd_data", 64'(core_rd_data),  64'(0));
      chk("rst_dma_gnt",      64'(dma_gnt),       64'(0));
      chk("rst_dma_rvalid",   64'(dma_rvalid),    64'(0));
      chk("rst_dma_rdata",    64'(dma_rdata),     64'(0));
      chk("rst_dccm_rd_en",   64'(dccm_rd_en),    64'(0));
      chk("rst_dccm_wr_en",   64'(dccm_wr_en),    64'(0));
      chk("rst_dccm_rd_addr", 64'(dccm_rd_addr),  64'(0));
      chk("rst_dccm_wr_addr", 64'(dccm_wr_addr),  64'(0));
      chk("rst_dccm_wr_data", 64'(dccm_wr_data),  64'(0));
      chk("rst_store_type",   64'(store_type),    64'(0));
      chk("rst_store_offset", 64'(store_offset),  64'(0));
      chk("rst_fsm_state",    64'(fsm_state),     64'(0));
      chk("rst_starve_count", 64'(starve_count),  64'(0));
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        c_rd, c_wr;
      logic [31:0] c_addr, c_wdata;
      logic [1:0]  c_type, c_off;
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic        e_stall, e_gnt, e_rd, e_wr;
      logic [31:0] e_addr, e_wdata;
      logic [1:0]  e_type, e_off;
      logic        chk_w;
   } vec_t;

   localparam int NV = 7;
   vec_t vec [NV];

   // ---------------- main sequence ----------------
   initial begin
      checks  = 0;
      errors  = 0;
      cycle   = 0;
      c_addr  = '0;
      c_wdata = '0;
      c_type  = '0;
      c_off   = '0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      set_idle();

      vec[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 2'b00, 1'b0};
      vec[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1, 32'h203, 32'h1234_5678,
                 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h1234_5678, 2'b10, 2'b00, 1'b1};
      vec[2] = '{1'b0, 1'b1, 32'h44, 32'hAABB_CCDD, 2'b00, 2'b11, 1'b1, 1'b0, 32'h80, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'hAABB_CCDD, 2'b00, 2'b11, 1'b1};
      vec[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 32'h3FF, 32'h0,
                 1'b0, 1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 2'b00, 2'b00, 1'b0};
      vec[4] = '{1'b0, 1'b1, 32'h12, 32'h5555_AAAA, 2'b01, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h12, 32'h5555_AAAA, 2'b01, 2'b10, 1'b1};
      vec[5] = '{1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1, 32'h60, 32'hFFFF_0000,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 2'b00, 1'b0};
      vec[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h5555_AAAA, 2'b01, 2'b10, 1'b1};

      do_reset();

      // ---- table-driven single-cycle vectors, idle cycle between each ----
      for (int i = 0; i < NV; i++) begin
         c_rd = vec[i].c_rd;   c_wr = vec[i].c_wr;
         c_addr = vec[i].c_addr; c_wdata = vec[i].c_wdata;
         c_type = vec[i].c_type; c_off = vec[i].c_off;
         d_req = vec[i].d_req; d_we = vec[i].d_we;
         d_addr = vec[i].d_addr; d_wdata = vec[i].d_wdata;
         eval_cycle();
         chk("tbl_stall",   64'(core_stall),   64'(vec[i].e_stall));
         chk("tbl_gnt",     64'(dma_gnt),      64'(vec[i].e_gnt));
         chk("tbl_rd_en",   64'(dccm_rd_en),   64'(vec[i].e_rd));
         chk("tbl_wr_en",   64'(dccm_wr_en),   64'(vec[i].e_wr));
         chk("tbl_rd_addr", 64'(dccm_rd_addr), 64'(vec[i].e_addr));
         chk("tbl_wr_addr", 64'(dccm_wr_addr), 64'(vec[i].e_addr));
         if (vec[i].chk_w) begin
            chk("tbl_wr_data", 64'(dccm_wr_data), 64'(vec[i].e_wdata));
            chk("tbl_type",    64'(store_type),   64'(vec[i].e_type));
            chk("tbl_offset",  64'(store_offset), 64'(vec[i].e_off));
         end
         next_cycle();
         idle_cycles(1);
      end
      idle_cycles(RD_LATENCY + 1);

      // ---- core-only load with a known memory word ----
      mem[32'h100] = 32'hDEAD_BEEF;
      for (int k = 0; k <= RD_LATENCY + 1; k++) begin
         c_rd   = (k == 0);
         c_addr = 32'h100;
         eval_cycle();
         chk("ld_stall", 64'(core_stall), 64'(0));
         if (k == 0) begin
            chk("ld_rd_en",   64'(dccm_rd_en),   64'(1));
            chk("ld_rd_addr", 64'(dccm_rd_addr), 64'(32'h100));
         end
         chk("ld_valid", 64'(core_rd_valid), 64'(k == RD_LATENCY));
         if (k == RD_LATENCY) chk("ld_data", 64'(core_rd_data), 64'(32'hDEAD_BEEF));
         next_cycle();
      end
      idle_cycles(2);

      // ---- starvation: core requests every cycle, DMA write held ----
      for (int k = 1; k <= 6; k++) begin
         c_rd = 1'b1; c_wr = 1'b0; c_addr = 32'h10 + 32'(4 * k);
         d_req = (k <= 5); d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hCAFE_0001;
         eval_cycle();
         if (k < 5) begin
            chk("stv_gnt_lose",   64'(dma_gnt),    64'(0));
            chk("stv_stall_lose", 64'(core_stall), 64'(0));
            if (k == 4) chk("stv_count", 64'(starve_count), 64'(3));
         end else if (k == 5) begin
            chk("stv_gnt_force",   64'(dma_gnt),      64'(1));
            chk("stv_stall_force", 64'(core_stall),   64'(1));
            chk("stv_wr_addr",     64'(dccm_wr_addr), 64'(32'h400));
            chk("stv_state",       64'(fsm_state),    64'(1));
         end else begin
            chk("stv_gnt_after",   64'(dma_gnt),    64'(0));
            chk("stv_stall_after", 64'(core_stall), 64'(0));
            chk("stv_core_rd",     64'(dccm_rd_en), 64'(1));
         end
         next_cycle();
      end
      idle_cycles(RD_LATENCY + 2);

      // ---- interleaved reads: core A then DMA B, returns in order ----
      mem[32'h300] = 32'h1;
      mem[32'h304] = 32'h2;
      for (int k = 0; k <= RD_LATENCY + 2; k++) begin
         c_rd = (k == 0); c_wr = 1'b0; c_addr = 32'h300;
         d_req = (k == 1); d_we = 1'b0; d_addr = 32'h304;
         eval_cycle();
         chk("ilv_core_valid", 64'(core_rd_valid), 64'(k == RD_LATENCY));
         chk("ilv_dma_valid",  64'(dma_rvalid),    64'(k == RD_LATENCY + 1));
         if (k == RD_LATENCY)     chk("ilv_core_data", 64'(core_rd_data), 64'(32'h1));
         if (k == RD_LATENCY + 1) chk("ilv_dma_data",  64'(dma_rdata),    64'(32'h2));
         next_cycle();
      end
      idle_cycles(2);

      // ---- DMA withdraws its request in the forced cycle ----
      for (int k = 1; k <= 6; k++) begin
         c_rd = 1'b1; c_wr = 1'b0; c_addr = 32'h500;
         d_req = (k <= 4); d_we = 1'b0; d_addr = 32'h600;
         eval_cycle();
         if (k == 5) begin
            chk("drop_state", 64'(fsm_state),  64'(1));
            chk("drop_gnt",   64'(dma_gnt),    64'(0));
            chk("drop_stall", 64'(core_stall), 64'(1));
            chk("drop_rd_en", 64'(dccm_rd_en), 64'(0));
            chk("drop_wr_en", 64'(dccm_wr_en), 64'(0));
         end else if (k == 6) begin
            chk("drop_state_after", 64'(fsm_state),    64'(0));
            chk("drop_count_after", 64'(starve_count), 64'(0));
            chk("drop_stall_after", 64'(core_stall),   64'(0));
         end
         next_cycle();
      end
      idle_cycles(RD_LATENCY + 2);

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            if ($urandom_range(0, 1) == 1) begin
               c_rd = 1'b1; c_wr = 1'b0;
            end else begin
               c_rd = 1'b0; c_wr = 1'b1;
            end
         end else begin
            c_rd = 1'b0; c_wr = 1'b0;
         end
         c_addr  = 32'($urandom_range(0, 1023));
         c_wdata = $urandom;
         c_type  = 2'($urandom_range(0, 2));
         c_off   = 2'($urandom_range(0, 3));
         if (!(d_req && !last_dgnt)) begin
            d_req   = ($urandom_range(0, 2) == 0);
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom_range(0, 1023));
            d_wdata = $urandom;
         end
         eval_cycle();
         next_cycle();
      end
      idle_cycles(RD_LATENCY + 2);

      // ---- reset while a read is outstanding ----
      c_rd = 1'b1; c_addr = 32'h150;
      eval_cycle();
      next_cycle();
      do_reset();
      idle_cycles(RD_LATENCY + 3);

      chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
